// File: rtl/dcache_req_sequencer.sv
// rtl/dcache_req_sequencer.sv - table-driven read/write request generator for the data-cache CPU port
// Optional stall counter output is enabled by defining DCACHE_REQ_SEQ_STALL_CNT_EN.
module dcache_req_sequencer #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 32,
    parameter int                N_READS    = 20,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                STRIDE     = 4,
    parameter logic [DATA_W-1:0] WDATA_SEED = DATA_W'(32'hA5A5_0000)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              loop_mode,
    input  logic              requested_data_to_mem,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] writedata,
    output logic              done,
    output logic [15:0]       issued_count
`ifdef DCACHE_REQ_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cycles
`endif
);

    localparam int                IDX_W    = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_index;
    logic                r_mem_read;
    logic                r_mem_write;
    logic [ADDR_W-1:0]   r_address;
    logic [DATA_W-1:0]   r_writedata;
    logic                r_done;
    logic [15:0]         r_issued;

    state_t              w_state_nxt;
    logic [IDX_W-1:0]    w_index_nxt;
    logic                w_rd_nxt;
    logic                w_wr_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]   w_wdata_nxt;
    logic                w_done_nxt;
    logic [15:0]         w_cnt_nxt;

    // DEPTH is a power of two, so index+1 at the last entry wraps to 0 for loop mode.
    logic [IDX_W-1:0]    w_load_idx;
    logic [ADDR_W-1:0]   w_entry_addr;
    logic                w_entry_rd;
    logic [DATA_W-1:0]   w_entry_wdata;

    assign w_load_idx    = (r_state == S_ISSUE) ? r_index + 1'b1 : '0;
    assign w_entry_addr  = BASE_ADDR + ADDR_W'(w_load_idx) * STRIDE_A;
    assign w_entry_rd    = (int'(w_load_idx) < N_READS);
    assign w_entry_wdata = w_entry_rd ? '0 : (WDATA_SEED ^ DATA_W'(w_entry_addr));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_index     <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_address   <= '0;
            r_writedata <= '0;
            r_done      <= 1'b0;
            r_issued    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_index     <= w_index_nxt;
            r_mem_read  <= w_rd_nxt;
            r_mem_write <= w_wr_nxt;
            r_address   <= w_addr_nxt;
            r_writedata <= w_wdata_nxt;
            r_done      <= w_done_nxt;
            r_issued    <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_rd_nxt    = r_mem_read;
        w_wr_nxt    = r_mem_write;
        w_addr_nxt  = r_address;
        w_wdata_nxt = r_writedata;
        w_done_nxt  = r_done;
        w_cnt_nxt   = r_issued;

        if (flush) begin
            w_state_nxt = S_IDLE;
            w_index_nxt = '0;
            w_rd_nxt    = 1'b0;
            w_wr_nxt    = 1'b0;
            w_addr_nxt  = '0;
            w_wdata_nxt = '0;
            w_done_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_ISSUE;
                    w_index_nxt = w_load_idx;
                    w_rd_nxt    = w_entry_rd;
                    w_wr_nxt    = !w_entry_rd;
                    w_addr_nxt  = w_entry_addr;
                    w_wdata_nxt = w_entry_wdata;
                end
                S_ISSUE: begin
                    if (!requested_data_to_mem) begin
                        w_cnt_nxt = r_issued + 16'd1;
                        if (r_index != LAST_IDX || loop_mode) begin
                            w_index_nxt = w_load_idx;
                            w_rd_nxt    = w_entry_rd;
                            w_wr_nxt    = !w_entry_rd;
                            w_addr_nxt  = w_entry_addr;
                            w_wdata_nxt = w_entry_wdata;
                        end else begin
                            w_state_nxt = S_DONE;
                            w_rd_nxt    = 1'b0;
                            w_wr_nxt    = 1'b0;
                            w_addr_nxt  = '0;
                            w_wdata_nxt = '0;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_DONE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign mem_read     = r_mem_read;
    assign mem_write    = r_mem_write;
    assign address      = r_address;
    assign writedata    = r_writedata;
    assign done         = r_done;
    assign issued_count = r_issued;

`ifdef DCACHE_REQ_SEQ_STALL_CNT_EN
    // Survives flush so stall statistics accumulate across restarts.
    logic [15:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (r_state == S_ISSUE && requested_data_to_mem
                     && r_stall_cycles != 16'hFFFF) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule
